// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the stream comparator
package cmp_pkg;

    // Frame collection state: gathering beats, or presenting a finished result
    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } cmp_state_e;

    // Per-word comparison result
    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_flags_t;

    // Counter width able to hold 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/word_cmp.sv
// rtl/word_cmp.sv - combinational unsigned compare of one word pair
module word_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    // Unsigned three-way comparison; exactly one output is set
    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/stream_comparator.sv
// rtl/stream_comparator.sv - multi-word frame comparator over a valid/ready stream
module stream_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_equal,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_diff_idx
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] IDX_NONE  = CNT_W'(DEPTH);

    cmp_state_e       state_q;
    cmp_state_e       state_d;
    cmp_flags_t       w_flags;

    // Running accumulators for the frame being collected
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_idx;
    logic             acc_found;
    logic             acc_gt;
    logic             acc_lt;

    // Accumulator values after folding in the current beat
    logic             accept;
    logic             last_beat;
    logic             new_diff;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] nxt_idx;
    logic             nxt_found;
    logic             nxt_gt;
    logic             nxt_lt;

    word_cmp #(
        .WIDTH (WIDTH)
    ) u_word_cmp (
        .a  (A),
        .b  (B),
        .eq (w_flags.eq),
        .gt (w_flags.gt),
        .lt (w_flags.lt)
    );

    // Beat acceptance and the accumulator update for the current beat
    always_comb begin
        accept    = (state_q == COLLECT) && in_valid && !flush;
        last_beat = (beat_cnt == LAST_BEAT);
        new_diff  = !acc_found && !w_flags.eq;
        nxt_cnt   = acc_cnt + CNT_W'(!w_flags.eq);
        nxt_idx   = new_diff ? beat_cnt : acc_idx;
        nxt_gt    = new_diff ? w_flags.gt : acc_gt;
        nxt_lt    = new_diff ? w_flags.lt : acc_lt;
        nxt_found = acc_found || !w_flags.eq;
    end

    // Next-state logic: final accepted beat enters REPORT, result handshake leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last_beat) state_d = REPORT;
            REPORT:  if (out_ready)           state_d = COLLECT;
            default:                          state_d = COLLECT;
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == COLLECT);
            out_valid <= (state_d == REPORT);
        end
    end

    // Accumulators and result registers; results are parked at idle values outside REPORT
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt       <= '0;
            acc_cnt        <= '0;
            acc_idx        <= IDX_NONE;
            acc_found      <= 1'b0;
            acc_gt         <= 1'b0;
            acc_lt         <= 1'b0;
            is_equal       <= 1'b0;
            a_gt_b         <= 1'b0;
            a_lt_b         <= 1'b0;
            mismatch_cnt   <= '0;
            first_diff_idx <= IDX_NONE;
        end else if (state_q == COLLECT) begin
            if (flush || (accept && last_beat)) begin
                beat_cnt  <= '0;
                acc_cnt   <= '0;
                acc_idx   <= IDX_NONE;
                acc_found <= 1'b0;
                acc_gt    <= 1'b0;
                acc_lt    <= 1'b0;
            end else if (accept) begin
                beat_cnt  <= beat_cnt + CNT_W'(1);
                acc_cnt   <= nxt_cnt;
                acc_idx   <= nxt_idx;
                acc_found <= nxt_found;
                acc_gt    <= nxt_gt;
                acc_lt    <= nxt_lt;
            end
            if (accept && last_beat) begin
                is_equal       <= !nxt_found;
                a_gt_b         <= nxt_gt;
                a_lt_b         <= nxt_lt;
                mismatch_cnt   <= nxt_cnt;
                first_diff_idx <= nxt_idx;
            end
        end else if (out_ready) begin
            is_equal       <= 1'b0;
            a_gt_b         <= 1'b0;
            a_lt_b         <= 1'b0;
            mismatch_cnt   <= '0;
            first_diff_idx <= IDX_NONE;
        end
    end

endmodule

// File: tb/tb_stream_comparator.sv
// tb/tb_stream_comparator.sv - scoreboard bench for stream_comparator
module tb_stream_comparator;

    typedef struct {
        logic       eq;
        logic       gt;
        logic       lt;
        logic [2:0] cnt;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic       is_equal;
    logic       a_gt_b;
    logic       a_lt_b;
    logic [2:0] mismatch_cnt;
    logic [2:0] first_diff_idx;

    logic        v1;
    logic        ir1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        ov1;
    logic        r1;
    logic        eq1;
    logic        gt1;
    logic        lt1;
    logic [0:0]  cnt1;
    logic [0:0]  idx1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    stream_comparator #(.WIDTH(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .A              (a),
        .B              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .is_equal       (is_equal),
        .a_gt_b         (a_gt_b),
        .a_lt_b         (a_lt_b),
        .mismatch_cnt   (mismatch_cnt),
        .first_diff_idx (first_diff_idx)
    );

    stream_comparator #(.WIDTH(16), .DEPTH(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .flush          (1'b0),
        .in_valid       (v1),
        .in_ready       (ir1),
        .A              (a1),
        .B              (b1),
        .out_valid      (ov1),
        .out_ready      (r1),
        .is_equal       (eq1),
        .a_gt_b         (gt1),
        .a_lt_b         (lt1),
        .mismatch_cnt   (cnt1),
        .first_diff_idx (idx1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-frame unsigned compare, word 0 in the top byte
    function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb);
        exp_t e;
        e.eq  = (fa == fb);
        e.gt  = (fa > fb);
        e.lt  = (fa < fb);
        e.cnt = 3'd0;
        e.idx = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (fa[31-8*i -: 8] != fb[31-8*i -: 8]) begin
                e.cnt = e.cnt + 3'd1;
                e.idx = 3'(i);
            end
        end
        return e;
    endfunction

    task automatic send_frame(input logic [31:0] fa, input logic [31:0] fb, input bit push);
        if (push) sb.push_back(model(fa, fb));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = fa[31-8*i -: 8];
            b = fb[31-8*i -: 8];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result();
        exp_t e;
        int   waited = 0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("out_valid", out_valid, 1);
        check("is_equal", is_equal, e.eq);
        check("a_gt_b", a_gt_b, e.gt);
        check("a_lt_b", a_lt_b, e.lt);
        check("mismatch_cnt", mismatch_cnt, e.cnt);
        check("first_diff_idx", first_diff_idx, e.idx);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("idle_idx", first_diff_idx, 4);
    endtask

    task automatic check_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_is_equal", is_equal, 0);
        check("rst_gt", a_gt_b, 0);
        check("rst_lt", a_lt_b, 0);
        check("rst_cnt", mismatch_cnt, 0);
        check("rst_idx", first_diff_idx, 4);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] fa;
        logic [31:0] fb;
        exp_t        e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0; r1 = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;

        // Equal frame: result present right after the 4th accept
        send_frame(32'h11223344, 32'h11223344, 1);
        check("eq_immediate", out_valid, 1);
        expect_result();

        // A greater at word 1
        send_frame(32'h108000FF, 32'h107F0100, 1);
        expect_result();

        // Result stall with in_valid held high
        send_frame(32'h01020304, 32'h01020305, 1);
        in_valid = 1'b1; a = 8'hAA; b = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_lt", a_lt_b, 1);
            check("stall_idx", first_diff_idx, 3);
        end
        in_valid = 1'b0;
        expect_result();
        send_frame(32'h00001100, 32'h00002200, 1);
        expect_result();

        // Flush together with the 3rd beat drops the partial frame
        @(negedge clk); in_valid = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk); a = 8'h03; b = 8'h03;
        @(negedge clk); a = 8'h09; b = 8'h07; flush = 1'b1;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        send_frame(32'hDEADBEEF, 32'hDEADBEEF, 1);
        expect_result();

        // Reset in REPORT, then mid-frame
        send_frame(32'h10000000, 32'h20000000, 0);
        check("pre_rst_valid", out_valid, 1);
        pulse_reset();
        @(negedge clk); in_valid = 1'b1; a = 8'h01; b = 8'h02;
        @(negedge clk); a = 8'h05; b = 8'h06;
        pulse_reset();
        send_frame(32'h00000005, 32'h00000009, 1);
        expect_result();

        // Random frames with sparse byte differences
        for (int n = 0; n < 6; n++) begin
            fa = $urandom;
            fb = fa;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 2) == 0) fb[8*i +: 8] = 8'($urandom);
            send_frame(fa, fb, 1);
            expect_result();
        end

        // Single-word frame
        e = '{eq: 1'b0, gt: 1'b0, lt: 1'b1, cnt: 3'd1, idx: 3'd0};
        @(negedge clk); v1 = 1'b1; a1 = 16'h0001; b1 = 16'hFFFF;
        @(negedge clk); v1 = 1'b0;
        check("d1_out_valid", ov1, 1);
        check("d1_in_ready", ir1, 0);
        check("d1_lt", lt1, e.lt);
        check("d1_gt", gt1, e.gt);
        check("d1_eq", eq1, e.eq);
        check("d1_idx", idx1, e.idx);
        check("d1_cnt", cnt1, e.cnt);
        r1 = 1'b1;
        @(negedge clk); r1 = 1'b0;
        check("d1_drop", ov1, 0);
        check("d1_ready", ir1, 1);
        @(negedge clk); v1 = 1'b1; a1 = 16'h1234; b1 = 16'h1234;
        @(negedge clk); v1 = 1'b0;
        check("d1_eq2", eq1, 1);
        check("d1_idx2", idx1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_comparator.md
# stream_comparator

Frame-level comparator that generalises the single-word equality check to multi-word operands streamed one word per beat. It accepts DEPTH word pairs (A, B) over a valid/ready handshake, then reports equality, unsigned magnitude ordering (most significant word first), mismatch count and first differing index. It sits between an operand source (memory reader or test-pattern generator) and a result consumer, and replaces ad-hoc chains of per-word equality checks.

## Interface
- WIDTH, 8: bits per word.
- DEPTH, 4: words per frame, ≥1; word 0 is the most significant.
- CNT_W, $clog2(DEPTH+1): width of count and index outputs.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abandon the partial frame.
- in_valid  in  1  A/B beat present.
- in_ready  out  1  block accepts a beat.
- A  in  WIDTH  operand A word.
- B  in  WIDTH  operand B word.
- out_valid  out  1  frame result present.
- out_ready  in  1  consumer takes the result.
- is_equal  out  1  all DEPTH word pairs equal.
- a_gt_b  out  1  A > B as unsigned DEPTH·WIDTH value.
- a_lt_b  out  1  A < B as unsigned DEPTH·WIDTH value.
- mismatch_cnt  out  CNT_W  number of unequal word pairs, 0..DEPTH.
- first_diff_idx  out  CNT_W  index of first unequal word; DEPTH when none.

## Operation
- States: COLLECT, REPORT.
- COLLECT: in_ready=1, out_valid=0. Each accepted beat (in_valid & in_ready) updates:
  - mismatch_cnt += (A!=B).
  - If no difference has been recorded yet and A!=B: record first_diff_idx=beat_cnt, gt=(A>B), lt=(A<B).
  - beat_cnt += 1.
- The accepted beat with beat_cnt==DEPTH-1 moves to REPORT and clears beat_cnt to 0.
- REPORT: in_ready=0, out_valid=1, all result outputs stable. is_equal=(mismatch_cnt==0). a_gt_b, a_lt_b come from the first differing word and are both 0 when is_equal. Exactly one of is_equal, a_gt_b, a_lt_b is 1.
- On out_valid & out_ready: return to COLLECT and clear all accumulators.
- flush in COLLECT: discards the partial frame and clears beat_cnt and accumulators. A beat in the same cycle is dropped, so flush wins.
- flush in REPORT: ignored; a completed result is never lost.
- rst has priority over everything. Mid-frame or mid-report it discards all work.
- Reset values: state=COLLECT, in_ready=1, out_valid=0, is_equal=0, a_gt_b=0, a_lt_b=0, mismatch_cnt=0, first_diff_idx=DEPTH, beat_cnt=0.
- Result outputs are 0 (first_diff_idx=DEPTH) whenever out_valid=0.
- All arithmetic is unsigned. beat_cnt never exceeds DEPTH-1, and mismatch_cnt saturates naturally at DEPTH.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- out_valid rises on the cycle after the last beat is accepted.
- Minimum frame period is DEPTH+1 cycles: DEPTH beats plus 1 report cycle with out_ready=1.
- in_ready rises on the cycle after the result handshake.
- out_valid holds with stable data for any out_ready stall length.
- DEPTH=1: every accepted beat goes straight to REPORT.
- Gaps in in_valid mid-frame are allowed and do not change results.

## Structure
- Shared package cmp_pkg:
  - state enum (COLLECT, REPORT).
  - result-flag struct {eq, gt, lt}.
  - function computing CNT_W from DEPTH.
- Sub-module word_cmp, parameter WIDTH, purely combinational: outputs eq, gt, lt for one word pair. stream_comparator instantiates one copy and holds the FSM, counters and result registers.

## Test plan
- Reset, then 4 beats A=B={0x11,0x22,0x33,0x44}: after the 4th accept, out_valid=1, is_equal=1, mismatch_cnt=0, first_diff_idx=4.
- Frame A={0x10,0x80,0x00,0xFF}, B={0x10,0x7F,0x01,0x00}: a_gt_b=1, a_lt_b=0, mismatch_cnt=3, first_diff_idx=1.
- Hold out_ready=0 for 10 cycles after a result with in_valid=1 throughout: in_ready=0, result unchanged, no beats consumed; after the handshake, the next frame starts at beat 0.
- Send 2 beats, assert flush together with a 3rd beat, then send a full equal frame: result is_equal=1 with mismatch_cnt=0; the pre-flush mismatch is not counted.
- Assert rst in REPORT and mid-frame: next cycle all outputs at reset values, in_ready=1.
- DEPTH=1, WIDTH=16: A=0x0001, B=0xFFFF gives out_valid on the next cycle with a_lt_b=1, first_diff_idx=0.
